// File: rtl/sipo_pkg.sv
// Shared constants and helpers for the serial-in parallel-out collector.
// Holds the default word width and the bit-counter width function.
package sipo_pkg;

  // Default word width, shared with the upstream serializer's bench.
  localparam int SIPO_WIDTH = 8;

  // Counter width able to hold 0..width (covers a trailing parity bit).
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_hold_reg.sv
// One-entry valid/ready output register with sticky overflow flag.
// Ports: clk, reset (sync, active-low), commit_i/word_i in, ready_i,
//        data_o/valid_o out, ovf_o sticky "word dropped".
module sipo_hold_reg #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          commit_i,
  input  logic [DW-1:0] word_i,
  input  logic          ready_i,
  output logic [DW-1:0] data_o,
  output logic          valid_o,
  output logic          ovf_o
);

  logic [DW-1:0] data_q, data_d;
  logic          valid_q, valid_d;
  logic          ovf_q, ovf_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    if (commit_i) begin
      if (!valid_q || ready_i) begin
        data_d  = word_i;
        valid_d = 1'b1;
      end else begin
        // Slot still occupied: drop the new word, keep the old one.
        ovf_d = 1'b1;
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/sipo_collector.sv
// Serial-in parallel-out collector: assembles WIDTH-bit words from din.
// Ports: clk, reset (sync, active-low), din/din_valid serial in,
//        dout/dout_valid/dout_ready word out, overflow sticky drop flag,
//        par_err even-parity error (only when SIPO_PARITY_EN is defined).
module sipo_collector
  import sipo_pkg::*;
#(
  parameter int WIDTH     = SIPO_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             din_valid,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overflow
`ifdef SIPO_PARITY_EN
  ,
  output logic             par_err
`endif
);

`ifdef SIPO_PARITY_EN
  localparam int F  = WIDTH + 1;
  localparam int HW = WIDTH + 1;
`else
  localparam int F  = WIDTH;
  localparam int HW = WIDTH;
`endif
  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(F - 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] shift_nxt;
  logic             commit;
  logic [HW-1:0]    hold_word;
  logic [HW-1:0]    hold_data;

  always_comb begin
    if (MSB_FIRST)
      shift_nxt = {shreg_q[WIDTH-2:0], din};
    else
      shift_nxt = {din, shreg_q[WIDTH-1:1]};
  end

  assign commit = din_valid && (cnt_q == LAST);

  always_comb begin
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    if (din_valid) begin
      shreg_d = shift_nxt;
      cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

`ifdef SIPO_PARITY_EN
  // On the parity edge shreg already holds all data bits; din is parity.
  assign hold_word = {^{shreg_q, din}, shreg_q};
  assign dout      = hold_data[WIDTH-1:0];
  assign par_err   = hold_data[WIDTH];
`else
  assign hold_word = shift_nxt;
  assign dout      = hold_data;
`endif

  sipo_hold_reg #(
    .DW (HW)
  ) u_hold (
    .clk      (clk),
    .reset    (reset),
    .commit_i (commit),
    .word_i   (hold_word),
    .ready_i  (dout_ready),
    .data_o   (hold_data),
    .valid_o  (dout_valid),
    .ovf_o    (overflow)
  );

endmodule
